pe2ddr: RTL and testbench
=========================

Name: pe2ddr

Overview:
- Write-back counterpart of the DDR-to-PE load path: drains per-PE accumulation buffers (abuf) into DDR after a compute pass.
- Walks the PEs enabled in a mask, in ascending index order. Reads each PE's buffer through a 1-cycle-latency read port and emits DDR write bursts on decoupled address and data channels.
- Sits beside the load path, sharing its DDR address/size conventions. A config/instruction decoder drives it with a start/done handshake.

Parameters:
- BUF_DEPTH, 256, abuf depth per PE (words)
- PE_NUM, 32, number of PEs
- DATA_W, 16, one lane width
- BATCH, 4, lanes per abuf word (BATCH*DATA_W must equal DDR_W)
- DDR_W, 64, DDR data beat width
- DDR_ADDR_W, 32, DDR address width (beat-addressed)
- BURST_W, 8, burst length field width
- ADDR_W, bw(BUF_DEPTH), abuf address width
- FIFO_DEPTH, 4, data skid FIFO depth (power of 2, >=2)

Ports:
- clk, input, 1, clock
- rst, input, 1, synchronous active-high reset
- start, input, 1, one-cycle pulse; accepted only in IDLE
- done, output, 1, one-cycle pulse when the job completes
- conf_st_addr, input, DDR_ADDR_W, first DDR beat address
- conf_trans_num, input, ADDR_W+1, words per PE (0..BUF_DEPTH)
- conf_burst, input, BURST_W, max beats per burst (>=1)
- conf_mask, input, PE_NUM, PEs to drain
- abuf_rd_en, output, 1, buffer read strobe
- abuf_rd_addr, output, ADDR_W, buffer read address
- abuf_rd_sel, output, bw(PE_NUM), PE select for read mux
- abuf_rd_data, input, BATCH*DATA_W, read data valid 1 cycle after abuf_rd_en
- ddr_addr, output, DDR_ADDR_W, burst start address
- ddr_size, output, BURST_W, burst length in beats
- ddr_addr_valid, output, 1, address handshake valid
- ddr_addr_ready, input, 1, address handshake ready
- ddr_data, output, DDR_W, write beat
- ddr_data_last, output, 1, final beat of a burst
- ddr_data_valid, output, 1, data handshake valid
- ddr_data_ready, input, 1, data handshake ready

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0. Reset mid-job aborts immediately; no done pulse is produced and in-flight data is discarded.
- Config is latched on start in IDLE. start in any other state is ignored.
- FSM states: IDLE, SEL, ADDR, DATA, FIN.
  - SEL: find the lowest set bit of the remaining mask. If none, go to FIN. Otherwise set rd_sel to that bit, clear it from the remaining mask, reset word count to 0, go to ADDR.
  - ADDR: ddr_addr_valid=1 with ddr_size=min(conf_burst, remaining words). Advance to DATA on ddr_addr_valid&&ddr_addr_ready.
  - DATA: stream that many beats. ddr_data_last=1 on the final beat. On the final beat handshake: if the PE has words left, go to ADDR; otherwise go to SEL.
  - FIN: done=1 for one cycle, then IDLE.
- Address arithmetic: next burst address = current + ddr_size, modulo 2^DDR_ADDR_W (wrap is allowed). PEs are packed contiguously in DDR, with no gap between PEs.
- Read prefetch:
  - abuf_rd_en may assert in ADDR or DATA whenever (fifo count + reads in flight) < FIFO_DEPTH and the current PE still has unread words.
  - abuf_rd_addr increments 0..trans_num-1 per PE.
  - Reads never cross to the next PE before SEL.
- FIFO output drives ddr_data. ddr_data_valid=(state==DATA)&&!fifo_empty. The FIFO pops on valid&&ready.
- With ready held high, sustained throughput is 1 beat/cycle. Address-to-first-data-beat is at most 2 cycles after the address handshake.
- Empty job: mask==0 or trans_num==0 → SEL→FIN. done asserts 2 cycles after start, with no DDR or abuf traffic.
- ddr_data_ready low: data is held stable, no beat is lost, and reads stall once the FIFO is full.
- Valid, once asserted, is held with stable payload until the handshake completes.

Optional Feature:
- Macro: PE2DDR_RELU_EN.
  - Defined: each DATA_W lane of ddr_data is replaced by 0 when its sign bit is 1 (ReLU), applied combinationally at the FIFO output with no added latency.
  - Undefined: data passes unmodified.

Test Plan:
- mask=32'h5, trans_num=5, burst=4, st_addr=0x100, ready always 1 → addresses 0x100/4, 0x104/1, 0x105/4, 0x109/1. PE0 words 0..4, then PE2 words 0..4. last on beats 4, 5, 9, 10. done once.
- Random toggling of ddr_data_ready and ddr_addr_ready on a 1-PE, 16-word, burst=8 job → all 16 words arrive in order, no duplicates, payload stable while stalled, FIFO never overflows.
- mask=0 (and separately trans_num=0) → done 2 cycles after start, no valid or rd_en ever asserted.
- rst asserted mid-DATA → next cycle all valids/rd_en/done are 0. A new job started afterward completes correctly.
- st_addr=0xFFFFFFFE, trans_num=4, burst=4 → single burst at 0xFFFFFFFE. A following PE's address wraps to 0x00000002.
- With PE2DDR_RELU_EN, abuf word {16'h8001,16'h7FFF,16'h0000,16'hFFFF} → ddr_data {0,16'h7FFF,0,0}. Without the macro → unchanged.

Source files
------------

// File: rtl/pe2ddr.sv
// pe2ddr: drains per-PE accumulation buffers into DDR as write bursts.
// PEs enabled in the mask are visited in ascending order. Each PE's buffer is
// read through a 1-cycle-latency port into a small skid FIFO that feeds the
// DDR data channel. Bursts are capped by conf_burst, and the PEs are packed
// contiguously in DDR.
// Optional feature: define PE2DDR_RELU_EN to zero every negative lane at the
// FIFO output.
module pe2ddr #(
    parameter int BUF_DEPTH  = 256,
    parameter int PE_NUM     = 32,
    parameter int DATA_W     = 16,
    parameter int BATCH      = 4,
    parameter int DDR_W      = 64,
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 8,
    parameter int ADDR_W     = $clog2(BUF_DEPTH),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      done,
    input  logic [DDR_ADDR_W-1:0]     conf_st_addr,
    input  logic [ADDR_W:0]           conf_trans_num,
    input  logic [BURST_W-1:0]        conf_burst,
    input  logic [PE_NUM-1:0]         conf_mask,
    output logic                      abuf_rd_en,
    output logic [ADDR_W-1:0]         abuf_rd_addr,
    output logic [$clog2(PE_NUM)-1:0] abuf_rd_sel,
    input  logic [BATCH*DATA_W-1:0]   abuf_rd_data,
    output logic [DDR_ADDR_W-1:0]     ddr_addr,
    output logic [BURST_W-1:0]        ddr_size,
    output logic                      ddr_addr_valid,
    input  logic                      ddr_addr_ready,
    output logic [DDR_W-1:0]          ddr_data,
    output logic                      ddr_data_last,
    output logic                      ddr_data_valid,
    input  logic                      ddr_data_ready
);

    localparam int SEL_W = $clog2(PE_NUM);
    localparam int TN_W  = ADDR_W + 1;
    localparam int CMP_W = (TN_W > BURST_W) ? TN_W : BURST_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_ADDR, S_DATA, S_FIN} state_t;

    state_t                  state_reg, state_next;
    logic [TN_W-1:0]         trans_num_reg;
    logic [BURST_W-1:0]      burst_reg;
    logic [PE_NUM-1:0]       mask_rem_reg;
    logic [SEL_W-1:0]        sel_reg;
    logic [DDR_ADDR_W-1:0]   ddr_addr_reg;
    logic [TN_W-1:0]         rd_cnt_reg;     // buffer reads issued for current PE
    logic [TN_W-1:0]         words_reg;      // words already covered by address beats
    logic [BURST_W-1:0]      burst_len_reg;
    logic [BURST_W-1:0]      beat_cnt_reg;
    logic                    rd_pend_reg;    // read issued last cycle, data arrives now

    logic [DDR_W-1:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]        fifo_cnt_reg;

    logic [TN_W-1:0]         remain;
    logic [BURST_W-1:0]      size_calc;
    logic [SEL_W-1:0]        sel_idx;
    logic                    sel_empty;
    logic                    addr_hs, data_hs, last_beat;
    logic                    fifo_push, fifo_pop, fifo_empty;
    logic [CNT_W-1:0]        occ;
    logic [DDR_W-1:0]        head, lane_out;

    // Handshakes, burst sizing and read-prefetch throttle.
    assign remain     = trans_num_reg - words_reg;
    assign sel_empty  = (mask_rem_reg == '0) || (trans_num_reg == '0);
    assign addr_hs    = ddr_addr_valid && ddr_addr_ready;
    assign data_hs    = ddr_data_valid && ddr_data_ready;
    assign last_beat  = (beat_cnt_reg == burst_len_reg - BURST_W'(1));
    assign fifo_empty = (fifo_cnt_reg == '0);
    assign fifo_push  = rd_pend_reg;
    assign fifo_pop   = data_hs;
    // Reads in flight count against capacity so a stall can never overflow.
    assign occ        = fifo_cnt_reg + CNT_W'(rd_pend_reg);

    assign ddr_addr_valid = (state_reg == S_ADDR);
    assign ddr_addr       = ddr_addr_reg;
    assign ddr_size       = (state_reg == S_ADDR) ? size_calc : '0;
    assign ddr_data_valid = (state_reg == S_DATA) && !fifo_empty;
    assign ddr_data_last  = ddr_data_valid && last_beat;
    assign ddr_data       = ddr_data_valid ? lane_out : '0;
    assign done           = (state_reg == S_FIN);
    assign abuf_rd_en     = ((state_reg == S_ADDR) || (state_reg == S_DATA)) &&
                            (rd_cnt_reg < trans_num_reg) && (occ < FIFO_FULL);
    assign abuf_rd_addr   = rd_cnt_reg[ADDR_W-1:0];
    assign abuf_rd_sel    = sel_reg;

    // Burst length is the smaller of the cap and the words this PE has left.
    always_comb begin
        size_calc = BURST_W'(remain);
        if (CMP_W'(burst_reg) < CMP_W'(remain)) begin
            size_calc = burst_reg;
        end
    end

    // Priority pick of the lowest remaining PE (scan downward so lowest wins).
    always_comb begin
        sel_idx = '0;
        for (int i = PE_NUM - 1; i >= 0; i--) begin
            if (mask_rem_reg[i]) begin
                sel_idx = SEL_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start) state_next = S_SEL;
            S_SEL:  state_next = sel_empty ? S_FIN : S_ADDR;
            S_ADDR: if (addr_hs) state_next = S_DATA;
            S_DATA: if (data_hs && last_beat) begin
                        state_next = (words_reg < trans_num_reg) ? S_ADDR : S_SEL;
                    end
            S_FIN:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Config latch, PE walk, address/word/beat counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            trans_num_reg <= '0;
            burst_reg     <= '0;
            mask_rem_reg  <= '0;
            sel_reg       <= '0;
            ddr_addr_reg  <= '0;
            rd_cnt_reg    <= '0;
            words_reg     <= '0;
            burst_len_reg <= '0;
            beat_cnt_reg  <= '0;
            rd_pend_reg   <= 1'b0;
        end else begin
            rd_pend_reg <= abuf_rd_en;
            if (abuf_rd_en) begin
                rd_cnt_reg <= rd_cnt_reg + TN_W'(1);
            end
            case (state_reg)
                S_IDLE: if (start) begin
                    trans_num_reg <= conf_trans_num;
                    burst_reg     <= conf_burst;
                    mask_rem_reg  <= conf_mask;
                    ddr_addr_reg  <= conf_st_addr;
                end
                S_SEL: if (!sel_empty) begin
                    sel_reg               <= sel_idx;
                    mask_rem_reg[sel_idx] <= 1'b0;
                    rd_cnt_reg            <= '0;
                    words_reg             <= '0;
                end
                S_ADDR: if (addr_hs) begin
                    burst_len_reg <= size_calc;
                    beat_cnt_reg  <= '0;
                    words_reg     <= words_reg + TN_W'(size_calc);
                    // Wraps modulo 2^DDR_ADDR_W; PEs follow each other with no gap.
                    ddr_addr_reg  <= ddr_addr_reg + DDR_ADDR_W'(size_calc);
                end
                S_DATA: if (data_hs) begin
                    beat_cnt_reg <= beat_cnt_reg + BURST_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Skid FIFO storage; small, so read combinationally from the head.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_reg] <= abuf_rd_data;
        end
    end

    // Skid FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (fifo_push && !fifo_pop) begin
                fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
            end else if (!fifo_push && fifo_pop) begin
                fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
            end
        end
    end

    assign head = fifo_mem[rd_ptr_reg];

    // Per-lane output stage: optional ReLU, otherwise pass-through.
    for (genvar gi = 0; gi < BATCH; gi++) begin : g_lane
`ifdef PE2DDR_RELU_EN
        assign lane_out[gi*DATA_W +: DATA_W] =
            head[gi*DATA_W + DATA_W - 1] ? '0 : head[gi*DATA_W +: DATA_W];
`else
        assign lane_out[gi*DATA_W +: DATA_W] = head[gi*DATA_W +: DATA_W];
`endif
    end

endmodule

// File: tb/tb_pe2ddr.sv
// tb_pe2ddr: directed jobs with a scoreboard of expected DDR address and data
// beats, a behavioural abuf with one cycle of read latency, and optional
// random ready stalls.
module tb_pe2ddr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        done;
    logic [31:0] conf_st_addr = '0;
    logic [8:0]  conf_trans_num = '0;
    logic [7:0]  conf_burst = '0;
    logic [31:0] conf_mask = '0;
    logic        abuf_rd_en;
    logic [7:0]  abuf_rd_addr;
    logic [4:0]  abuf_rd_sel;
    logic [63:0] abuf_rd_data = '0;
    logic [31:0] ddr_addr;
    logic [7:0]  ddr_size;
    logic        ddr_addr_valid;
    logic        ddr_addr_ready = 1'b1;
    logic [63:0] ddr_data;
    logic        ddr_data_last;
    logic        ddr_data_valid;
    logic        ddr_data_ready = 1'b1;

    pe2ddr dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .conf_st_addr(conf_st_addr), .conf_trans_num(conf_trans_num),
        .conf_burst(conf_burst), .conf_mask(conf_mask),
        .abuf_rd_en(abuf_rd_en), .abuf_rd_addr(abuf_rd_addr),
        .abuf_rd_sel(abuf_rd_sel), .abuf_rd_data(abuf_rd_data),
        .ddr_addr(ddr_addr), .ddr_size(ddr_size),
        .ddr_addr_valid(ddr_addr_valid), .ddr_addr_ready(ddr_addr_ready),
        .ddr_data(ddr_data), .ddr_data_last(ddr_data_last),
        .ddr_data_valid(ddr_data_valid), .ddr_data_ready(ddr_data_ready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          act_cnt = 0;
    int          done_cnt = 0;
    bit          rand_mode = 1'b0;
    logic [39:0] exp_a [$];   // {addr, size}
    logic [64:0] exp_d [$];   // {last, data}
    bit          pend_v = 1'b0;
    int          pend_sel = 0;
    int          pend_addr = 0;
    bit          a_stall = 1'b0, d_stall = 1'b0, a_wait = 1'b0, tput_exp = 1'b0;
    logic [63:0] a_hold, d_hold;
    logic        d_hold_last;
    int          a_cyc = 0;

    // Buffer content: unique per (PE, word) with sign bits mixed across lanes.
    function automatic logic [63:0] abuf_word(int sel, int addr);
        logic [15:0] k;
        k = 16'(sel * 256 + addr);
        if (sel == 7 && addr == 0) return 64'h8001_7FFF_0000_FFFF;
        return {16'h8000 | k, k & 16'h7FFF, ~k, k ^ 16'h5A5A};
    endfunction

    function automatic logic [63:0] exp_word(int sel, int addr);
        logic [63:0] w;
        w = abuf_word(sel, addr);
`ifdef PE2DDR_RELU_EN
        for (int l = 0; l < 4; l++) begin
            if (w[l*16+15]) w[l*16 +: 16] = 16'h0;
        end
`endif
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [31:0] st, input int tn, input int burst, input logic [31:0] mask);
        logic [31:0] a;
        int sz;
        a = st;
        for (int p = 0; p < 32; p++) begin
            if (mask[p]) begin
                for (int w = 0; w < tn; w += sz) begin
                    sz = (burst < tn - w) ? burst : tn - w;
                    exp_a.push_back({a, 8'(sz)});
                    for (int b = 0; b < sz; b++) exp_d.push_back({(b == sz - 1), exp_word(p, w + b)});
                    a = a + 32'(sz);
                end
            end
        end
    endtask

    // One clock: advance the abuf model, drive readies, then score this cycle.
    task automatic tick();
        logic [39:0] ea;
        logic [64:0] ed;
        @(posedge clk);
        #1;
        cyc++;
        abuf_rd_data = pend_v ? abuf_word(pend_sel, pend_addr) : 64'h0;
        pend_v = abuf_rd_en;
        pend_sel = int'(abuf_rd_sel);
        pend_addr = int'(abuf_rd_addr);
        ddr_addr_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        ddr_data_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rst) begin
            a_stall = 0; d_stall = 0; a_wait = 0; tput_exp = 0;
            return;
        end
        if (ddr_addr_valid || ddr_data_valid || abuf_rd_en) act_cnt++;
        if (done) done_cnt++;
        if (a_stall) begin
            check("addr_hold_valid", 64'(ddr_addr_valid), 64'd1);
            check("addr_hold_payload", {24'h0, ddr_addr, ddr_size}, a_hold);
        end
        if (d_stall) begin
            check("data_hold_valid", 64'(ddr_data_valid), 64'd1);
            check("data_hold_payload", ddr_data, d_hold);
            check("data_hold_last", 64'(ddr_data_last), 64'(d_hold_last));
        end
        if (a_wait && (ddr_data_valid || (cyc - a_cyc > 2))) begin
            check("addr_to_data_latency", 64'(ddr_data_valid && (cyc - a_cyc <= 2)), 64'd1);
            a_wait = 0;
        end
        if (tput_exp) check("sustained_throughput", 64'(ddr_data_valid), 64'd1);
        tput_exp = 0;
        if (ddr_addr_valid && ddr_addr_ready) begin
            check("addr_expected", 64'(exp_a.size() > 0), 64'd1);
            if (exp_a.size() > 0) begin
                ea = exp_a.pop_front();
                check("ddr_addr", 64'(ddr_addr), 64'(ea[39:8]));
                check("ddr_size", 64'(ddr_size), 64'(ea[7:0]));
            end
            a_wait = 1; a_cyc = cyc;
        end
        if (ddr_data_valid && ddr_data_ready) begin
            check("data_expected", 64'(exp_d.size() > 0), 64'd1);
            if (exp_d.size() > 0) begin
                ed = exp_d.pop_front();
                check("ddr_data", ddr_data, ed[63:0]);
                check("ddr_data_last", 64'(ddr_data_last), 64'(ed[64]));
            end
            if (!rand_mode && !ddr_data_last) tput_exp = 1;
        end
        a_stall = ddr_addr_valid && !ddr_addr_ready;
        a_hold = {24'h0, ddr_addr, ddr_size};
        d_stall = ddr_data_valid && !ddr_data_ready;
        d_hold = ddr_data;
        d_hold_last = ddr_data_last;
    endtask

    task automatic pulse_start(input logic [31:0] st, input int tn, input int burst, input logic [31:0] mask);
        conf_st_addr = st;
        conf_trans_num = 9'(tn);
        conf_burst = 8'(burst);
        conf_mask = mask;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_job(input logic [31:0] st, input int tn, input int burst,
                           input logic [31:0] mask, input bit rm);
        rand_mode = rm;
        push_exp(st, tn, burst, mask);
        done_cnt = 0;
        pulse_start(st, tn, burst, mask);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
        check("job_done_seen", 64'(done_cnt), 64'd1);
        tick();
        tick();
        check("done_single_pulse", 64'(done_cnt), 64'd1);
        check("addr_queue_drained", 64'(exp_a.size()), 64'd0);
        check("data_queue_drained", 64'(exp_d.size()), 64'd0);
        rand_mode = 1'b0;
    endtask

    task automatic empty_job(input int tn, input logic [31:0] mask);
        act_cnt = 0;
        pulse_start(32'h40, tn, 4, mask);
        check("empty_done_t1", 64'(done), 64'd0);
        tick();
        check("empty_done_t2", 64'(done), 64'd1);
        tick();
        check("empty_done_after", 64'(done), 64'd0);
        check("empty_no_traffic", 64'(act_cnt), 64'd0);
    endtask

    initial begin
        bit seen;
        // Reset state.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_done", 64'(done), 64'd0);
        check("rst_addr_valid", 64'(ddr_addr_valid), 64'd0);
        check("rst_data_valid", 64'(ddr_data_valid), 64'd0);
        check("rst_rd_en", 64'(abuf_rd_en), 64'd0);
        check("rst_ddr_addr", 64'(ddr_addr), 64'd0);
        check("rst_ddr_size", 64'(ddr_size), 64'd0);
        check("rst_ddr_data", ddr_data, 64'd0);
        check("rst_rd_sel", 64'(abuf_rd_sel), 64'd0);

        // Two PEs, bursts split 4+1, contiguous packing.
        run_job(32'h100, 5, 4, 32'h5, 1'b0);
        // Random backpressure on both channels.
        run_job(32'h0, 16, 8, 32'h8, 1'b1);
        run_job(32'h40, 7, 3, 32'h8000_0011, 1'b1);
        // Empty jobs.
        empty_job(5, 32'h0);
        empty_job(0, 32'hFF);
        // Full-depth PE, last PE index.
        run_job(32'h1000, 256, 64, 32'h8000_0000, 1'b0);

        // Reset in the middle of the data phase.
        push_exp(32'h300, 8, 4, 32'h3);
        pulse_start(32'h300, 8, 4, 32'h3);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            seen = ddr_data_valid;
        end
        check("midrst_reached_data", 64'(seen), 64'd1);
        rst = 1'b1;
        tick();
        check("midrst_addr_valid", 64'(ddr_addr_valid), 64'd0);
        check("midrst_data_valid", 64'(ddr_data_valid), 64'd0);
        check("midrst_rd_en", 64'(abuf_rd_en), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        rst = 1'b0;
        exp_a.delete();
        exp_d.delete();
        pend_v = 0;
        done_cnt = 0;
        repeat (3) tick();
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        run_job(32'h200, 6, 4, 32'h2, 1'b0);

        // Address wrap across 2^32.
        run_job(32'hFFFF_FFFE, 4, 4, 32'h3, 1'b0);
        // ReLU vector (pass-through unless the feature is built in).
        run_job(32'h10, 1, 1, 32'h80, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
